dmi_access_ctrl: RTL

- DMI initiator engine on the DTM side. It drives the request channel and consumes the response channel that the debug module serves.
- It takes one decoded DMI access per update pulse from the JTAG shift/update logic and runs it as a valid/ready transaction.
- It tracks the sticky DMI error status (dmistat), generates the synchronous DMI response-FIFO clear, and aborts hung transactions with a timeout.

---
 rtl/dmi_access_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/dmi_access_ctrl.sv
// DTM-side DMI initiator: turns one decoded update-DR access into a valid/ready
// transaction with the debug module, tracking sticky dmistat and hung-access timeouts.
module dmi_access_ctrl #(
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned CntWidth      = $clog2(TimeoutCycles + 1)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        access_valid_i,
  input  logic [1:0]  access_op_i,
  input  logic [6:0]  access_addr_i,
  input  logic [31:0] access_data_i,
  input  logic        dmireset_i,
  input  logic        dmihardreset_i,
  output logic        busy_o,
  output logic [1:0]  error_o,
  output logic [31:0] rdata_o,
  output logic        dmi_rst_no,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [40:0] dmi_req_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [33:0] dmi_resp_i
);

  localparam int unsigned CntW = (CntWidth == 0) ? 1 : CntWidth;
  localparam logic [CntW-1:0] CntLast =
    (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;

  localparam logic [1:0] OpRead     = 2'd1;
  localparam logic [1:0] OpWrite    = 2'd2;
  localparam logic [1:0] RespFailed = 2'd2;
  localparam logic [1:0] RespBusy   = 2'd3;
  localparam logic [1:0] ErrOk      = 2'd0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      error_q, error_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [40:0]     req_q, req_d;
  logic            rst_n_q, rst_n_d;

  logic            req_hs;
  logic            resp_hs;
  logic            op_valid;
  logic            accept;
  logic            overrun;
  logic            timeout_hit;
  logic [31:0]     resp_data;
  logic [1:0]      resp_code;

  assign resp_data = dmi_resp_i[33:2];
  assign resp_code = dmi_resp_i[1:0];

  assign req_hs   = (state_q == REQ) && dmi_req_ready_i;
  assign resp_hs  = (state_q == WAIT) && dmi_resp_valid_i;
  assign op_valid = (access_op_i == OpRead) || (access_op_i == OpWrite);
  assign accept   = (state_q == IDLE) && access_valid_i && (error_q == ErrOk) &&
                    op_valid && !dmihardreset_i;
  assign overrun  = (state_q != IDLE) && access_valid_i && (error_q == ErrOk);

  // A handshake landing in the expiry cycle beats the timeout.
  always_comb begin
    timeout_hit = 1'b0;
    if ((TimeoutCycles != 0) && (state_q != IDLE) && (cnt_q >= CntLast) &&
        !req_hs && !resp_hs) begin
      timeout_hit = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (req_hs) begin
          state_d = WAIT;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (resp_hs || timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (dmihardreset_i) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept || dmihardreset_i) begin
      cnt_d = '0;
    end else if ((state_q != IDLE) && (cnt_q != {CntW{1'b1}})) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Only the first error is latched; dmireset loses to a coincident set event.
  always_comb begin
    error_d = error_q;
    if (dmireset_i) begin
      error_d = ErrOk;
    end
    if (error_q == ErrOk) begin
      if (overrun) begin
        error_d = RespBusy;
      end
      if (timeout_hit) begin
        error_d = RespFailed;
      end
      if (resp_hs && ((resp_code == RespFailed) || (resp_code == RespBusy))) begin
        error_d = resp_code;
      end
    end
    if (dmihardreset_i) begin
      error_d = ErrOk;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    req_d   = req_q;
    rst_n_d = !(dmihardreset_i || timeout_hit);
    if (resp_hs && !dmihardreset_i) begin
      rdata_d = resp_data;
    end
    if (accept) begin
      req_d = {access_addr_i, access_op_i, access_data_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      error_q <= ErrOk;
      rdata_q <= '0;
      req_q   <= '0;
      rst_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      rst_n_q <= rst_n_d;
    end
  end

  always_comb begin
    busy_o           = 1'b0;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b0;
    case (state_q)
      REQ: begin
        busy_o          = 1'b1;
        dmi_req_valid_o = 1'b1;
      end
      WAIT: begin
        busy_o           = 1'b1;
        dmi_resp_ready_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign error_o    = error_q;
  assign rdata_o    = rdata_q;
  assign dmi_req_o  = req_q;
  assign dmi_rst_no = rst_n_q;

  a_one_channel: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(dmi_req_valid_o && dmi_resp_ready_o));

  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (dmi_req_valid_o && !dmi_req_ready_i) |=> $stable(dmi_req_o));

endmodule
